// File: rtl/wb_pkg.sv
// Shared constants for the rv32i write-back stage: load formats and FSM encoding.
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_LOAD = 1'b1;

endpackage

// File: rtl/load_extract_rv32i.sv
// Combinational load alignment: selects the byte/half lane and sign- or zero-extends it.
module load_extract_rv32i
  import wb_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_lo_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
  end

  // Half lane follows addr_lo[1] only; a misaligned LH reads the enclosing half.
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_load_std_rv32i.sv
// rv32i write-back stage: retires ALU results directly and stalls on loads until the read response.
// Optional load timeout fault is enabled by defining WB_LOAD_TIMEOUT_EN.
module wb_load_std_rv32i
  import wb_pkg::*;
`ifdef WB_LOAD_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  input  logic [4:0]  IN_RD,
  input  logic [31:0] IN_DATA,
  input  logic        IN_IS_LOAD,
  input  logic [2:0]  IN_FUNCT3,
  input  logic [1:0]  IN_ADDR_LO,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  output logic        MEM_RREADY,
  output logic [4:0]  WADDR,
  output logic [31:0] WDATA,
  output logic [4:0]  FWD_REG_ADDR,
  output logic        MEM_WAIT,
`ifdef WB_LOAD_TIMEOUT_EN
  output logic        RETIRE,
  output logic        LOAD_FAULT
`else
  output logic        RETIRE
`endif
);

  logic [0:0]  state_q, state_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  fwd_q, fwd_d;
  logic        retire_q, retire_d;
  logic [31:0] ext_data;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  load_extract_rv32i u_extract (
    .funct3_i  (f3_q),
    .addr_lo_i (lo_q),
    .word_i    (MEM_RDATA),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    f3_d     = f3_q;
    lo_d     = lo_q;
    fwd_d    = fwd_q;
    waddr_d  = 5'd0;
    wdata_d  = 32'd0;
    retire_d = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d    = cnt_q;
    fault_d  = 1'b0;
`endif
    if (state_q == ST_IDLE) begin
      fwd_d = 5'd0;
      if (IN_VALID && !IN_IS_LOAD) begin
        waddr_d  = IN_RD;
        wdata_d  = IN_DATA;
        retire_d = 1'b1;
      end else if (IN_VALID) begin
        state_d = ST_WAIT_LOAD;
        rd_d    = IN_RD;
        f3_d    = IN_FUNCT3;
        lo_d    = IN_ADDR_LO;
        fwd_d   = IN_RD;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
    end else if (MEM_RVALID) begin
      // A response always wins over a timeout landing in the same cycle.
      state_d  = ST_IDLE;
      waddr_d  = rd_q;
      wdata_d  = ext_data;
      fwd_d    = 5'd0;
      retire_d = 1'b1;
    end
`ifdef WB_LOAD_TIMEOUT_EN
    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d  = ST_IDLE;
      waddr_d  = rd_q;
      fwd_d    = 5'd0;
      retire_d = 1'b1;
      fault_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      rd_q     <= 5'd0;
      f3_q     <= 3'd0;
      lo_q     <= 2'd0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      fwd_q    <= 5'd0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      fwd_q    <= fwd_d;
      retire_q <= retire_d;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign LOAD_FAULT = fault_q;
`endif

  assign WADDR        = waddr_q;
  assign WDATA        = wdata_q;
  assign FWD_REG_ADDR = fwd_q;
  assign RETIRE       = retire_q;
  assign MEM_WAIT     = (state_q == ST_WAIT_LOAD);
  assign MEM_RREADY   = (state_q == ST_WAIT_LOAD);

endmodule

// File: doc/wb_load_std_rv32i.md
Name: wb_load_std_rv32i

Overview:
- Write-back stage that drives the register-file write port (WADDR/WDATA) and the forwarding hazard address (FWD_REG_ADDR).
- Retires one instruction per cycle from the memory stage.
- Loads: holds the pipeline via MEM_WAIT until the data-memory read response arrives, then aligns and extends the data and writes it back.
- Sits between the memory-access stage / data bus and the rv32i register file.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT_LOAD before a load fault. Used only with WB_LOAD_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- IN_VALID  in  1  retiring instruction present
- IN_RD  in  5  destination register; 0 = no write
- IN_DATA  in  32  ALU result; don't-care for loads
- IN_IS_LOAD  in  1  instruction is a load
- IN_FUNCT3  in  3  load format
- IN_ADDR_LO  in  2  load byte address [1:0]
- MEM_RVALID  in  1  read-response valid
- MEM_RDATA  in  32  read-response word
- MEM_RREADY  out  1  ready to accept a read response
- WADDR  out  5  register-file write address; 0 = no write
- WDATA  out  32  register-file write data
- FWD_REG_ADDR  out  5  destination of the outstanding load, not yet readable
- MEM_WAIT  out  1  freeze upstream pipeline
- RETIRE  out  1  one-cycle pulse per completed instruction
- LOAD_FAULT  out  1  load timeout pulse; present only with WB_LOAD_TIMEOUT_EN

Behaviour:
- Reset:
  - RST is synchronous, active-high; CLK is the clock.
  - RST forces state IDLE and drives all outputs to 0.
  - RST wins over every other input. An in-flight load is abandoned and its late MEM_RVALID is ignored.
- Outputs:
  - WADDR, WDATA, FWD_REG_ADDR and RETIRE are registered.
  - MEM_WAIT and MEM_RREADY are decoded from the registered state: asserted when state == WAIT_LOAD.
- FSM, two states: IDLE and WAIT_LOAD.
- IDLE, IN_VALID=1, IN_IS_LOAD=0:
  - Next cycle: WADDR=IN_RD, WDATA=IN_DATA, RETIRE=1.
  - Stay IDLE; throughput 1/cycle.
- IDLE, IN_VALID=1, IN_IS_LOAD=1:
  - Capture rd, funct3 and addr_lo.
  - Go to WAIT_LOAD; next cycle FWD_REG_ADDR=rd, WADDR=0, WDATA=0, RETIRE=0.
- IDLE, IN_VALID=0:
  - Next cycle WADDR=0, WDATA=0, RETIRE=0.
- WAIT_LOAD, MEM_RVALID=0:
  - Hold all captured state. WADDR=0.
  - IN_* are ignored; upstream is frozen by MEM_WAIT.
- WAIT_LOAD, MEM_RVALID=1 (response accepted; MEM_RREADY=1):
  - Next cycle: WADDR=rd, WDATA=extract(MEM_RDATA), FWD_REG_ADDR=0, RETIRE=1.
  - Return to IDLE, so MEM_WAIT drops in the same cycle the write is presented.
- MEM_RVALID while in IDLE is ignored.
- Load with rd=0: completes normally, but WADDR=0 and FWD_REG_ADDR=0 throughout.
- extract(), using byte lane b=addr_lo and half lane h=addr_lo[1]:
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend half h; addr_lo[0] is ignored.
  - 010 LW: full word; addr_lo is ignored.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend half h.
  - Other funct3 values: full word.
- FLUSH is not an input: instructions reaching this stage are committed.

Optional Feature:
- Macro: WB_LOAD_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider wait counter clears on entry to WAIT_LOAD and increments each WAIT_LOAD cycle without MEM_RVALID.
  - When the counter reaches TIMEOUT_CYCLES-1 without a response: next cycle LOAD_FAULT=1 for one cycle, WADDR=rd, WDATA=0, RETIRE=1, FWD_REG_ADDR=0; state returns to IDLE.
  - MEM_RVALID arriving in that same cycle takes priority: normal completion, no fault.
- When undefined: no counter, no LOAD_FAULT port, and WAIT_LOAD waits indefinitely.

Decomposition:
- Shared package wb_pkg:
  - funct3 constants (LB, LH, LW, LBU, LHU).
  - FSM state encoding: IDLE=1'b0, WAIT_LOAD=1'b1.
- One combinational sub-module, load_extract_rv32i: inputs funct3, addr_lo, word; output 32-bit extended data.

Test Plan:
- ALU retire: IN_VALID=1, IN_RD=5, IN_DATA=0x1234_5678, IN_IS_LOAD=0 → next cycle WADDR=5, WDATA=0x12345678, RETIRE=1; MEM_WAIT stays 0.
- LB with latency: load rd=7, funct3=000, addr_lo=3; MEM_RVALID=1 after 3 cycles with MEM_RDATA=0x80FF_0102.
  - Waiting: MEM_WAIT=1 and FWD_REG_ADDR=7 for 3 cycles.
  - Then WADDR=7, WDATA=0xFFFF_FF80, FWD_REG_ADDR=0.
- Halfword formats on MEM_RDATA=0x8001_7FFE with addr_lo=2:
  - LHU → 0x0000_8001.
  - LH → 0xFFFF_8001.
  - LH with addr_lo=0 → 0x0000_7FFE.
- rd=0 load plus back-to-back ALU: LW rd=0 completes with WADDR=0 throughout; an ALU instruction held by MEM_WAIT retires the cycle after.
- Reset mid-load: RST during WAIT_LOAD → all outputs 0 and IDLE; MEM_RVALID=1 the following cycle → no write, RETIRE=0.
- With WB_LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=4: no response → after 4 WAIT_LOAD cycles, LOAD_FAULT=1 pulse, WADDR=rd, WDATA=0, MEM_WAIT drops.
